// File: rtl/csel_pkg.sv
// csel_pkg: shared definitions for the pipelined carry-select adder/subtractor.
//   csel_stages()     number of pipeline stages for a WIDTH/BLK/BPS choice
//   CSEL_BLK_DEFAULT  default bits per carry-select block
//   csel_ctl_t        per-stage control register (valid + stage carry-out)
// The parameter-sized parts of a stage register (resolved sum bits, pending
// operand slices, carry into the top bit) are declared next to the stage in
// the top module because their widths depend on the stage index.
package csel_pkg;

  localparam int unsigned CSEL_BLK_DEFAULT = 4;

  typedef struct packed {
    logic valid;
    logic carry;
  } csel_ctl_t;

  function automatic int unsigned csel_stages(input int unsigned width,
                                              input int unsigned blk,
                                              input int unsigned bps);
    return width / (blk * bps);
  endfunction

endpackage

// File: rtl/csel_block.sv
// csel_block: one combinational carry-select block.
//   a, b  BLK-bit operand slices
//   ci    incoming carry that selects between the two precomputed results
//   s     BLK-bit sum slice
//   co    carry out of the block
// Two ripple adders run in parallel, one assuming carry-in 0 and one
// assuming carry-in 1; the real carry only drives the final mux.
module csel_block
  import csel_pkg::*;
#(
  parameter int unsigned BLK = CSEL_BLK_DEFAULT
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK-1:0] s0;
  logic [BLK-1:0] s1;
  logic [BLK:0]   c0;
  logic [BLK:0]   c1;

  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (a[i] & c0[i]) | (b[i] & c0[i]);
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (a[i] & c1[i]) | (b[i] & c1[i]);
    end
  end

  assign s  = ci ? s1 : s0;
  assign co = ci ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/csel_addsub_pipe.sv
// csel_addsub_pipe: pipelined carry-select adder/subtractor with valid/ready.
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake (beat taken when both high)
//   a, b, cin, sub       operands; sub=0: a+b+cin, sub=1: a-b (cin ignored)
//   out_valid, out_ready result handshake
//   sum                  WIDTH-bit result modulo 2^WIDTH
//   cout                 carry out of the MSB (inverted borrow when sub=1)
//   ovf                  two's-complement overflow
// Stage k resolves BPS blocks of BLK bits each; resolved bits accumulate in
// the stage registers while the unresolved operand slices ride along.
module csel_addsub_pipe
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = CSEL_BLK_DEFAULT,
  parameter int unsigned BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = BLK * BPS;
  localparam int unsigned S  = csel_stages(WIDTH, BLK, BPS);

  if (SW == 0 || WIDTH == 0 || (WIDTH % SW) != 0) begin : g_bad_width
    $error("csel_addsub_pipe: WIDTH must be a nonzero multiple of BLK*BPS");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [S-1:0]     vld;
  logic [S-1:0]     adv;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  // Ready chain walks from the output back to the input; a local running
  // term keeps the vector free of self-dependencies.
  always_comb begin
    logic run;
    adv = '0;
    run = out_ready;
    for (int unsigned i = 0; i < S; i++) begin
      run            = !vld[S-1-i] || run;
      adv[S-1-i]     = run;
    end
  end

  assign in_ready = adv[0] & ~rst;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int unsigned AW = WIDTH - k * SW;

    logic [AW-1:0]         ain;
    logic [AW-1:0]         bin;
    logic [SW-1:0]         sa;
    logic [SW-1:0]         sb;
    logic [SW-1:0]         ss;
    logic                  sc;
    logic                  sco;
    logic                  vin;
    logic [(k+1)*SW-1:0]   sum_d;
    logic [(k+1)*SW-1:0]   sum_q;
    csel_ctl_t             ctl_q;

    if (k == 0) begin : g_src
      assign ain   = a;
      assign bin   = b_eff;
      assign sc    = cin_eff;
      assign vin   = in_valid;
      assign sum_d = ss;
    end else begin : g_src
      assign ain   = g_stage[k-1].g_hold.a_q;
      assign bin   = g_stage[k-1].g_hold.b_q;
      assign sc    = g_stage[k-1].ctl_q.carry;
      assign vin   = g_stage[k-1].ctl_q.valid;
      assign sum_d = {ss, g_stage[k-1].sum_q};
    end

    assign sa = ain[SW-1:0];
    assign sb = bin[SW-1:0];

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic bci;
      logic bco;
      if (j == 0) begin : g_ci
        assign bci = sc;
      end else begin : g_ci
        assign bci = g_blk[j-1].bco;
      end
      csel_block #(.BLK(BLK)) u_blk (
        .a  (sa[j*BLK +: BLK]),
        .b  (sb[j*BLK +: BLK]),
        .ci (bci),
        .s  (ss[j*BLK +: BLK]),
        .co (bco)
      );
    end

    assign sco    = g_blk[BPS-1].bco;
    assign vld[k] = ctl_q.valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv[k]) begin
        ctl_q.valid <= vin;
        ctl_q.carry <= sco;
        sum_q       <= sum_d;
      end
    end

    if (k < S - 1) begin : g_hold
      logic [AW-SW-1:0] a_q;
      logic [AW-SW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= ain[AW-1:SW];
          b_q <= bin[AW-1:SW];
        end
      end
    end else begin : g_top
      // Carry into the MSB recovered from the MSB sum bit and operand bits.
      logic ctop_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ctop_q <= 1'b0;
        end else if (adv[k]) begin
          ctop_q <= ss[SW-1] ^ sa[SW-1] ^ sb[SW-1];
        end
      end
    end
  end

  assign out_valid = g_stage[S-1].ctl_q.valid;
  assign sum       = g_stage[S-1].sum_q;
  assign cout      = g_stage[S-1].ctl_q.carry;
  assign ovf       = g_stage[S-1].g_top.ctop_q ^ g_stage[S-1].ctl_q.carry;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
module tb_csel_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks;
  int failures;

  logic [33:0] q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[14];

  csel_addsub_pipe #(.WIDTH(32), .BLK(4), .BPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [32:0] r;
    logic        co;
    logic        ov;
    if (s) begin
      r  = {1'b0, x - y};
      co = (x >= y);
      ov = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + 33'(c);
      co = r[32];
      ov = (x[31] == y[31]) && (r[31] != x[31]);
    end
    return {ov, co, r[31:0]};
  endfunction

  // One clock cycle: drive at the falling edge, observe handshakes, then
  // let the rising edge happen.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ic, input logic is, input logic ordy,
                      output logic acc, output logic took);
    logic [33:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    took = out_valid && ordy;
    if (took) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("stream", {30'b0, ovf, cout, sum}, {30'b0, e});
      end
    end
    if (acc) q.push_back(model(ia, ib, ic, is));
    @(posedge clk);
  endtask

  // Latency counts rising edges starting with the accept edge.
  task automatic send_one(input vec_t v, input int unsigned idx);
    int unsigned lat;
    logic        seen;
    @(negedge clk);
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    sub       = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(4));
    chk($sformatf("v%0d_sum", idx), 64'(sum), 64'(v.s));
    chk($sformatf("v%0d_cout", idx), 64'(cout), 64'(v.co));
    chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.ov));
  endtask

  initial begin
    logic        acc;
    logic        took;
    int unsigned n_acc;
    int unsigned n_took;
    int unsigned sent;
    int unsigned got;
    int unsigned cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;
    logic        riv;
    logic        bad;

    checks   = 0;
    failures = 0;

    tbl[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5]  = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0};
    tbl[6]  = '{32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tbl[11] = '{32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 32'h10101010, 1'b0, 1'b0};
    tbl[12] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0};
    tbl[13] = '{32'h12345678, 32'h02345678, 1'b0, 1'b1, 32'h10000000, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Directed single-beat vectors
    for (int unsigned i = 0; i < 14; i++) send_one(tbl[i], i);

    // Backpressure: fill with out_ready low, first result must hold.
    q.delete();
    n_acc = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b1, 32'd100 + 32'd3 * n_acc, n_acc, 1'b0, 1'b0, 1'b0, acc, took);
      if (acc) n_acc++;
      #1;
      if (i >= 3) begin
        chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'(1));
        chk($sformatf("hold%0d_sum", i), 64'(sum), 64'(100));
      end
    end
    chk("full_accepts", 64'(n_acc), 64'(4));
    chk("full_in_ready", 64'(in_ready), 64'(0));

    // Release: remaining beats enter while results drain, one per cycle.
    n_took = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step(n_acc < 10, 32'd100 + 32'd3 * n_acc, n_acc, 1'b0, 1'b0, 1'b1, acc, took);
      if (acc) n_acc++;
      if (took) n_took++;
    end
    chk("drain_accepts", 64'(n_acc), 64'(10));
    chk("drain_results", 64'(n_took), 64'(10));
    chk("drain_queue_empty", 64'(q.size()), 64'(0));

    // Mid-flight reset discards three beats.
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 32'h00000100 + i, 32'h1, 1'b0, 1'b0, 1'b1, acc, took);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready_after", 64'(in_ready), 64'(1));
    q.delete();
    bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, took);
      if (out_valid) bad = 1'b1;
    end
    chk("midrst_no_delivery", 64'(bad), 64'(0));

    // Random valid/ready stream against the reference model.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 3000 || q.size() != 0) && cyc < 40000) begin
      riv = (sent < 3000) && ($urandom_range(0, 99) < 70);
      ra  = $urandom();
      rb  = $urandom();
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      step(riv, ra, rb, rc, rs, $urandom_range(0, 99) < 60, acc, took);
      if (acc) sent++;
      if (took) got++;
      cyc++;
    end
    chk("stream_received", 64'(got), 64'(3000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
